spi_slave: RTL and testbench

SPI mode-0 slave (CPOL=0, CPHA=0, MSB first) that exchanges 8-bit words with an external master while running entirely in the system `clk` domain. The asynchronous pins `sck`, `ss` and `mosi` are synchronized and edge-detected. Each received byte is presented on `dout` with a one-cycle `done` strobe, and the next transmit byte is taken from `din`. Internal pipeline registers are exported as observation ports for bring-up and verification.

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_sync.sv | 25 ++
 rtl/spi_slave.sv | 94 +++++++++
 tb/tb_spi_slave.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI mode-0 slave.
// Word width and synchronizer depth used across the slice.
package spi_pkg;
   localparam int SPI_DATA_W      = 8;
   localparam int SPI_SYNC_STAGES = 2;
endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous pin.
// Exposes the last-stage D input and Q output.
module spi_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   output logic d,
   output logic q
);
   logic [STAGES-1:0] r;
   logic [STAGES:0]   tap;

   assign tap = {r, a};
   assign d   = tap[STAGES-1];
   assign q   = tap[STAGES];

   // shift the pin through the flop chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r <= {STAGES{RST_VAL}};
      else      r <= tap[STAGES-1:0];
   end
endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave running in the clk domain.
// Pins are synchronized, sck edges detected, words shifted MSB first.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ss,
   input  logic              sck,
   input  logic              mosi,
   output logic              miso,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic              done,
   output logic              ss_d,
   output logic              ss_q,
   output logic              mosi_d,
   output logic              mosi_q,
   output logic [DATA_W-1:0] data_d,
   output logic [DATA_W-1:0] data_q
);
   localparam int            CW   = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   logic              sck_q;
   logic              sck_d_unused;
   logic              sck_old;
   logic              rise;
   logic              fall;
   logic              last;
   logic [CW-1:0]     bit_cnt;
   logic [DATA_W-1:0] shifted;

   spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk(clk), .rst(rst), .a(sck), .d(sck_d_unused), .q(sck_q)
   );

   spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
      .clk(clk), .rst(rst), .a(ss), .d(ss_d), .q(ss_q)
   );

   spi_sync #(.STAGES(SPI_SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
      .clk(clk), .rst(rst), .a(mosi), .d(mosi_d), .q(mosi_q)
   );

   assign rise    = sck_q & ~sck_old;
   assign fall    = ~sck_q & sck_old;
   assign shifted = {data_q[DATA_W-2:0], mosi_q};
   assign last    = ~ss_q & rise & (bit_cnt == LAST);

   // shift register next state: reload from din when idle or word ends
   always_comb begin
      data_d = data_q;
      if (ss_q || last) data_d = din;
      else if (rise)    data_d = shifted;
   end

   // shift register and previous-sck history
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         sck_old <= 1'b0;
      end else begin
         data_q  <= data_d;
         sck_old <= sck_q;
      end
   end

   // bit counter; deselect clears it, which also aborts partial words
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      bit_cnt <= '0;
      else if (ss_q) bit_cnt <= '0;
      else if (rise) bit_cnt <= last ? '0 : bit_cnt + 1'b1;
   end

   // received word capture with one-cycle strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dout <= '0;
         done <= 1'b0;
      end else begin
         done <= last;
         if (last) dout <= shifted;
      end
   end

   // miso follows the MSB while idle and on each sck fall
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)             miso <= 1'b0;
      else if (ss_q | fall) miso <= data_q[DATA_W-1];
   end
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave.
// Master model drives pins; scoreboard tracks received words.
module tb_spi_slave;
   logic       clk = 1'b0;
   logic       rst;
   logic       ss;
   logic       sck;
   logic       mosi;
   logic [7:0] din;
   logic       miso;
   logic [7:0] dout;
   logic       done;
   logic       ss_d, ss_q, mosi_d, mosi_q;
   logic [7:0] data_d, data_q;

   int checks = 0;
   int errors = 0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];

   typedef struct {
      logic [7:0] tx;
      logic [7:0] dn;
      int         nb;
      bit         keep;
      bit         exp_done;
      logic [7:0] exp_dout;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t tbl[8];

   spi_slave #(.DATA_W(8)) dut (
      .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
      .miso(miso), .din(din), .dout(dout), .done(done),
      .ss_d(ss_d), .ss_q(ss_q), .mosi_d(mosi_d), .mosi_q(mosi_q),
      .data_d(data_d), .data_q(data_q)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst && done) got_q.push_back(dout);

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic begin_session(input logic [7:0] d);
      din = d;
      ss  = 1'b1;
      wait_clk(4);
      ss = 1'b0;
      wait_clk(4);
   endtask

   task automatic end_session();
      ss = 1'b1;
      wait_clk(6);
   endtask

   task automatic word(input logic [7:0] tx, input int nb,
                       input logic [7:0] nxt, output logic [7:0] got);
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
         sck  = 1'b0;
         mosi = tx[7-i];
         wait_clk(2);
         sck = 1'b1;
         if (i == 0) din = nxt;
         wait_clk(2);
         got[7-i] = miso;
      end
      sck = 1'b0;
      wait_clk(2);
   endtask

   task automatic drain();
      logic [7:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() > 0) chk("done_dout", got_q.pop_front(), e);
         else chk("done_missing", 32'hFFFF_FFFF, e);
      end
      chk("extra_done", got_q.size(), 0);
      got_q.delete();
   endtask

   initial begin
      logic [7:0] g, nxt, m, cur, tx, model_dout;
      int nw, nb;
      bit ab;

      tbl[0] = '{8'hA5, 8'h3C, 8, 1'b0, 1'b1, 8'hA5, 8'h3C};
      tbl[1] = '{8'h55, 8'h66, 8, 1'b1, 1'b1, 8'h55, 8'h66};
      tbl[2] = '{8'hAA, 8'h81, 8, 1'b0, 1'b1, 8'hAA, 8'h81};
      tbl[3] = '{8'hF0, 8'h12, 5, 1'b0, 1'b0, 8'hAA, 8'h12};
      tbl[4] = '{8'h0F, 8'h34, 8, 1'b0, 1'b1, 8'h0F, 8'h34};
      tbl[5] = '{8'h55, 8'h5A, 8, 1'b1, 1'b1, 8'h55, 8'h5A};
      tbl[6] = '{8'h55, 8'hA5, 8, 1'b1, 1'b1, 8'h55, 8'hA5};
      tbl[7] = '{8'h55, 8'h3C, 8, 1'b0, 1'b1, 8'h55, 8'h3C};

      rst = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0; din = 8'hFF;
      wait_clk(3);
      chk("rst_dout", dout, 8'h00);
      chk("rst_done", done, 1'b0);
      chk("rst_miso", miso, 1'b0);
      chk("rst_ss_q", ss_q, 1'b1);
      chk("rst_data_q", data_q, 8'h00);
      rst = 1'b1;
      wait_clk(4);
      chk("idle_data_q", data_q, 8'hFF);
      chk("idle_miso", miso, 1'b1);
      chk("idle_ss_d", ss_d, 1'b1);

      for (int k = 0; k < 8; k++) begin
         if (k == 0 || !tbl[k-1].keep) begin_session(tbl[k].dn);
         nxt = tbl[k].keep ? tbl[k+1].dn : 8'($urandom);
         word(tbl[k].tx, tbl[k].nb, nxt, g);
         m = 8'hFF << (8 - tbl[k].nb);
         chk($sformatf("tbl%0d_miso", k), g & m, tbl[k].exp_miso & m);
         chk($sformatf("tbl%0d_dout", k), dout, tbl[k].exp_dout);
         if (tbl[k].exp_done) exp_q.push_back(tbl[k].exp_dout);
         if (!tbl[k].keep) begin
            end_session();
            chk($sformatf("tbl%0d_dout_idle", k), dout, tbl[k].exp_dout);
            drain();
         end
      end

      begin_session(8'h99);
      word(8'h5E, 3, 8'h99, g);
      rst = 1'b0;
      #1;
      chk("mid_rst_dout", dout, 8'h00);
      chk("mid_rst_done", done, 1'b0);
      chk("mid_rst_miso", miso, 1'b0);
      chk("mid_rst_ss_q", ss_q, 1'b1);
      chk("mid_rst_mosi_q", mosi_q, 1'b0);
      chk("mid_rst_data_q", data_q, 8'h00);
      ss = 1'b1; mosi = 1'b0;
      wait_clk(2);
      rst = 1'b1;
      wait_clk(2);
      drain();
      begin_session(8'h3C);
      word(8'hC3, 8, 8'h00, g);
      exp_q.push_back(8'hC3);
      chk("post_rst_miso", g, 8'h3C);
      chk("post_rst_dout", dout, 8'hC3);
      end_session();
      drain();
      model_dout = 8'hC3;

      for (int s = 0; s < 30; s++) begin
         nw  = $urandom_range(1, 3);
         cur = 8'($urandom);
         begin_session(cur);
         for (int w = 0; w < nw; w++) begin
            tx  = 8'($urandom);
            ab  = (w == nw - 1) && ($urandom_range(0, 3) == 0);
            nb  = ab ? $urandom_range(1, 7) : 8;
            nxt = 8'($urandom);
            word(tx, nb, nxt, g);
            m = 8'hFF << (8 - nb);
            chk("rnd_miso", g & m, cur & m);
            if (!ab) begin
               model_dout = tx;
               exp_q.push_back(tx);
            end
            chk("rnd_dout", dout, model_dout);
            cur = nxt;
         end
         end_session();
         drain();
         chk("rnd_dout_idle", dout, model_dout);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
